// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter: FSM state encoding and data width.
package fifo_uart_pkg;
   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP} utx_state_t;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read side plus serial line and status of the UART drain stage.
// The master modport is the transmitter that pops the FIFO; slave is the surrounding logic.
interface fifo_uart_tx_if;
   import fifo_uart_pkg::*;

   logic                   enable;
   logic                   fifo_empty;
   logic [UART_DATA_W-1:0] fifo_data;
   logic                   fifo_rd_en;
   logic                   tx;
   logic                   busy;
   logic                   byte_done;

   modport master (
      input  enable, fifo_empty, fifo_data,
      output fifo_rd_en, tx, busy, byte_done
   );

   modport slave (
      output enable, fifo_empty, fifo_data,
      input  fifo_rd_en, tx, busy, byte_done
   );
endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear holds the count at zero so every bit period starts aligned to a state entry.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             bit_tick
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   assign bit_tick = (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || bit_tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from a synchronous FIFO and sends it as UART 8N1/8N2, LSB first.
// All outputs are registered, so each is loaded with the value belonging to the next state.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   fifo_uart_tx_if.master   bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   utx_state_t             state;
   logic [UART_DATA_W-1:0] shift;
   logic [2:0]             bit_cnt;
   logic                   stop_cnt;
   logic                   tx_q;
   logic                   rd_en_q;
   logic                   busy_q;
   logic                   done_q;

   logic [CNT_W-1:0]       baud_count;
   logic                   bit_tick;
   logic                   baud_clear;
   logic                   final_stop;
   logic                   start_ok;

   // The divider only runs while a bit is on the line, so it is at zero on entry to START.
   assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LATCH);
   assign final_stop = (STOP_BITS == 1) || stop_cnt;
   assign start_ok   = bus.enable && !bus.fifo_empty;

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (baud_clear),
      .count    (baud_count),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx_q     <= 1'b1;
         rd_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state   <= FETCH;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               state <= LATCH;
            end
            LATCH: begin
               shift <= bus.fifo_data;
               state <= START;
               tx_q  <= 1'b0;
            end
            START: begin
               if (bit_tick) begin
                  state <= DATA;
                  tx_q  <= shift[0];
               end
            end
            DATA: begin
               if (bit_tick) begin
                  // bit_cnt wraps 7->0 on the final data bit, ready for the next frame.
                  bit_cnt <= bit_cnt + 3'd1;
                  shift   <= shift >> 1;
                  if (bit_cnt == 3'd7) begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     tx_q  <= shift[1];
                  end
               end
            end
            STOP: begin
               if (final_stop && (baud_count == PRE_LAST)) begin
                  done_q <= 1'b1;
               end
               if (bit_tick) begin
                  if (final_stop) begin
                     stop_cnt <= 1'b0;
                     if (start_ok) begin
                        state   <= FETCH;
                        rd_en_q <= 1'b1;
                     end else begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx         = tx_q;
   assign bus.fifo_rd_en = rd_en_q;
   assign bus.busy       = busy_q;
   assign bus.byte_done  = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small FIFO model feeds two instances (4 clk/bit 1 stop, 16 clk/bit 2 stop).
module tb_fifo_uart_tx;
   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   fifo_uart_tx_if if0 ();
   fifo_uart_tx_if if1 ();

   fifo_uart_tx #(.CLKS_PER_BIT(4),  .STOP_BITS(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   fifo_uart_tx #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO models: registered read data, valid the cycle after the pop strobe.
   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   int wr0 = 0;
   int rd0 = 0;
   int wr1 = 0;
   int rd1 = 0;
   int done0 = 0;
   int done1 = 0;

   assign if0.fifo_empty = (wr0 == rd0);
   assign if1.fifo_empty = (wr1 == rd1);

   always @(posedge clk) begin
      if (if0.fifo_rd_en) begin
         if0.fifo_data <= mem0[rd0[3:0]];
         rd0 <= rd0 + 1;
      end
      if (if1.fifo_rd_en) begin
         if1.fifo_data <= mem1[rd1[3:0]];
         rd1 <= rd1 + 1;
      end
      if (if0.byte_done) done0 <= done0 + 1;
      if (if1.byte_done) done1 <= done1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int sel, input logic [7:0] b);
      if (sel == 1) begin
         mem1[wr1[3:0]] = b;
         wr1++;
      end else begin
         mem0[wr0[3:0]] = b;
         wr0++;
      end
   endtask

   function automatic logic get_tx(input int sel);
      return (sel == 1) ? if1.tx : if0.tx;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 1) ? if1.byte_done : if0.byte_done;
   endfunction

   // Checks tx and byte_done on every cycle of a frame starting at the next negedge.
   task automatic check_frame(input int sel, input logic [7:0] b, input int cpb, input int nstop,
                              input int max_cyc, input int drop_at);
      int total;
      total = (9 + nstop) * cpb;
      for (int i = 0; i < total && i < max_cyc; i++) begin
         int   bi;
         logic exp_tx;
         @(negedge clk);
         bi = i / cpb;
         if (bi == 0)      exp_tx = 1'b0;
         else if (bi <= 8) exp_tx = b[bi-1];
         else              exp_tx = 1'b1;
         check($sformatf("tx_%0d_%02h_c%0d", sel, b, i), 32'(get_tx(sel)), 32'(exp_tx));
         check($sformatf("done_%0d_%02h_c%0d", sel, b, i), 32'(get_done(sel)), 32'(i == total - 1));
         if (i == drop_at) if0.enable = 1'b0;
      end
   endtask

   initial begin
      logic any_rd, any_low, any_busy;
      rst = 1'b0;
      if0.enable = 1'b1;
      if1.enable = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tx",   32'(if0.tx),         32'd1);
      check("rst_busy", 32'(if0.busy),       32'd0);
      check("rst_rd",   32'(if0.fifo_rd_en), 32'd0);
      check("rst_done", 32'(if0.byte_done),  32'd0);
      check("rst_tx1",  32'(if1.tx),         32'd1);

      // 1: idle with empty FIFO and enable high
      rst = 1'b0;
      any_rd = 1'b0; any_low = 1'b0; any_busy = 1'b0;
      repeat (100) begin
         @(negedge clk);
         any_rd   = any_rd | if0.fifo_rd_en;
         any_low  = any_low | ~if0.tx;
         any_busy = any_busy | if0.busy;
      end
      check("idle_rd",   32'(any_rd),   32'd0);
      check("idle_tx",   32'(any_low),  32'd0);
      check("idle_busy", 32'(any_busy), 32'd0);

      // 2: single byte 0xA5
      push(0, 8'hA5);
      @(negedge clk);
      check("a5_fetch_rd",   32'(if0.fifo_rd_en), 32'd1);
      check("a5_fetch_busy", 32'(if0.busy),       32'd1);
      check("a5_fetch_tx",   32'(if0.tx),         32'd1);
      @(negedge clk);
      check("a5_latch_rd", 32'(if0.fifo_rd_en), 32'd0);
      check("a5_latch_tx", 32'(if0.tx),         32'd1);
      check_frame(0, 8'hA5, 4, 1, 1000, -1);
      @(negedge clk);
      check("a5_end_busy", 32'(if0.busy),      32'd0);
      check("a5_end_done", 32'(if0.byte_done), 32'd0);
      check("a5_pops",     32'(rd0),           32'd1);
      check("a5_dones",    32'(done0),         32'd1);

      // 3: back-to-back 0x01, 0x80
      push(0, 8'h01);
      push(0, 8'h80);
      @(negedge clk);
      check("b2b_rd1", 32'(if0.fifo_rd_en), 32'd1);
      @(negedge clk);
      check_frame(0, 8'h01, 4, 1, 1000, -1);
      @(negedge clk);
      check("b2b_rd2",      32'(if0.fifo_rd_en), 32'd1);
      check("b2b_gap1_tx",  32'(if0.tx),         32'd1);
      check("b2b_gap_busy", 32'(if0.busy),       32'd1);
      @(negedge clk);
      check("b2b_gap2_rd", 32'(if0.fifo_rd_en), 32'd0);
      check("b2b_gap2_tx", 32'(if0.tx),         32'd1);
      check_frame(0, 8'h80, 4, 1, 1000, -1);
      @(negedge clk);
      check("b2b_end_busy", 32'(if0.busy), 32'd0);
      check("b2b_pops",     32'(rd0),      32'd3);
      check("b2b_dones",    32'(done0),    32'd3);

      // 4: enable gating, then drop during DATA of frame 1
      if0.enable = 1'b0;
      push(0, 8'h3C);
      push(0, 8'hFF);
      push(0, 8'h5A);
      repeat (20) @(negedge clk);
      check("dis_pops", 32'(rd0),     32'd3);
      check("dis_busy", 32'(if0.busy), 32'd0);
      if0.enable = 1'b1;
      @(negedge clk);
      check("en_rd", 32'(if0.fifo_rd_en), 32'd1);
      @(negedge clk);
      check_frame(0, 8'h3C, 4, 1, 1000, 12);
      @(negedge clk);
      check("drop_busy", 32'(if0.busy),       32'd0);
      check("drop_rd",   32'(if0.fifo_rd_en), 32'd0);
      repeat (10) @(negedge clk);
      check("drop_pops",  32'(rd0),      32'd4);
      check("drop_dones", 32'(done0),    32'd4);
      check("drop_idle",  32'(if0.busy), 32'd0);

      // 5: reset during DATA bit 4 of 0xFF
      if0.enable = 1'b1;
      @(negedge clk);
      check("ff_rd", 32'(if0.fifo_rd_en), 32'd1);
      @(negedge clk);
      check_frame(0, 8'hFF, 4, 1, 21, -1);
      check("ff_busy_pre", 32'(if0.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_tx",   32'(if0.tx),         32'd1);
      check("arst_busy", 32'(if0.busy),       32'd0);
      check("arst_done", 32'(if0.byte_done),  32'd0);
      check("arst_rd",   32'(if0.fifo_rd_en), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rd", 32'(if0.fifo_rd_en), 32'd1);
      @(negedge clk);
      check_frame(0, 8'h5A, 4, 1, 1000, -1);
      @(negedge clk);
      check("post_busy",  32'(if0.busy), 32'd0);
      check("post_pops",  32'(rd0),      32'd6);
      check("post_dones", 32'(done0),    32'd5);

      // 6: 2 stop bits, 16 clk/bit, byte 0x00
      if1.enable = 1'b1;
      push(1, 8'h00);
      @(negedge clk);
      check("s2_rd", 32'(if1.fifo_rd_en), 32'd1);
      @(negedge clk);
      check("s2_latch_tx", 32'(if1.tx), 32'd1);
      check_frame(1, 8'h00, 16, 2, 1000, -1);
      @(negedge clk);
      check("s2_end_busy", 32'(if1.busy), 32'd0);
      check("s2_pops",     32'(rd1),      32'd1);
      check("s2_dones",    32'(done1),    32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
